// File: rtl/pixel_clip_fifo.sv
// Clips plot requests to the visible screen and buffers the surviving pixels
// in a small FIFO that drains to the VGA adapter at up to one pixel per cycle.
module pixel_clip_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               in_x,
  input  logic [6:0]               in_y,
  input  logic [2:0]               in_colour,
  input  logic                     in_plot,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     out_en,
  output logic [7:0]               vga_x,
  output logic [6:0]               vga_y,
  output logic [2:0]               vga_colour,
  output logic                     vga_plot,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic [15:0]              clip_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = 18;

  logic [PW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   clip_q, clip_d;
  logic [7:0]    vga_x_q, vga_x_d;
  logic [6:0]    vga_y_q, vga_y_d;
  logic [2:0]    vga_colour_q, vga_colour_d;
  logic          vga_plot_q, vga_plot_d;

  logic in_screen, accept, push, clip, pop, is_empty, not_full;

  // Occupancy flags decode straight from the level register.
  assign is_empty = (level_q == '0);
  assign not_full = (level_q != LW'(DEPTH));

  assign in_screen = (32'(in_x) < SCREEN_W) && (32'(in_y) < SCREEN_H);
  assign accept    = in_plot && not_full && !flush;
  assign push      = accept && in_screen;
  assign clip      = accept && !in_screen;
  assign pop       = out_en && !is_empty && !flush;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    clip_d       = clip_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        {vga_x_d, vga_y_d, vga_colour_d} = mem_q[rd_ptr_q];
        vga_plot_d = 1'b1;
      end
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (!push && pop) level_d = level_q - LW'(1);
    end

    // Clip counter saturates rather than wrapping.
    if (clip && (clip_q != 16'hFFFF)) clip_d = clip_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      clip_q       <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      clip_q       <= clip_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y, in_colour};
  end

  assign in_ready   = not_full;
  assign empty      = is_empty;
  assign level      = level_q;
  assign clip_count = clip_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// Bench for pixel_clip_fifo: directed scenarios plus random traffic, all
// compared against a queue-based model of the clip-and-buffer behaviour.
module tb_pixel_clip_fifo;

  localparam int DEPTH = 16;
  localparam int SW    = 160;
  localparam int SH    = 120;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_x = '0;
  logic [6:0] in_y = '0;
  logic [2:0] in_colour = '0;
  logic       in_plot = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       out_en = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [4:0] level;
  logic       empty;
  logic [15:0] clip_count;

  pixel_clip_fifo #(.DEPTH(DEPTH), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_plot(in_plot),
    .in_ready(in_ready), .flush(flush), .out_en(out_en),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .level(level), .empty(empty), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a queue of buffered pixels and the last emitted pixel.
  logic [17:0] q[$];
  int          m_clip = 0;
  logic [7:0]  e_x = '0;
  logic [6:0]  e_y = '0;
  logic [2:0]  e_c = '0;
  logic        e_plot = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("vga_plot", 32'(vga_plot), 32'(e_plot));
    check_eq("vga_x", 32'(vga_x), 32'(e_x));
    check_eq("vga_y", 32'(vga_y), 32'(e_y));
    check_eq("vga_colour", 32'(vga_colour), 32'(e_c));
    check_eq("level", 32'(level), 32'(q.size()));
    check_eq("empty", 32'(empty), 32'(q.size() == 0));
    check_eq("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    check_eq("clip_count", 32'(clip_count), 32'(m_clip));
  endtask

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic step();
    bit acc, pp;
    logic [17:0] px;
    acc = in_plot && (q.size() != DEPTH) && !flush;
    pp  = out_en && (q.size() != 0) && !flush;
    e_plot = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      if (pp) begin
        px = q.pop_front();
        {e_x, e_y, e_c} = px;
        e_plot = 1'b1;
      end
      if (acc) begin
        if (int'(in_x) < SW && int'(in_y) < SH) q.push_back({in_x, in_y, in_colour});
        else if (m_clip < 65535) m_clip++;
      end
    end
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_clip = 0;
    e_x = '0; e_y = '0; e_c = '0; e_plot = 1'b0;
  endtask

  task automatic check_in_reset();
    check_eq("rst_plot", 32'(vga_plot), 32'd0);
    check_eq("rst_x", 32'(vga_x), 32'd0);
    check_eq("rst_y", 32'(vga_y), 32'd0);
    check_eq("rst_colour", 32'(vga_colour), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_clip", 32'(clip_count), 32'd0);
  endtask

  // Called one time unit after a rising edge; asserts reset mid-cycle.
  task automatic do_reset();
    in_plot = 1'b0; flush = 1'b0; out_en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_in_reset();
    model_reset();
    @(posedge clk); #1;
    check_in_reset();
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(in_ready), 32'd1);
    check_eq("post_rst_empty", 32'(empty), 32'd1);
    check_eq("post_rst_level", 32'(level), 32'd0);
  endtask

  task automatic drive(input int x, input int y, input int c, input bit plot);
    in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c); in_plot = plot;
  endtask

  initial begin
    int i, run, max_lvl;
    bit acc;

    // Reset state before any edge.
    #2 check_in_reset();
    @(posedge clk); #1;
    do_reset();

    // Single pixel latency.
    out_en = 1'b1;
    drive(10, 20, 5, 1'b1);
    step();
    check_eq("single_no_bypass", 32'(vga_plot), 32'd0);
    drive(0, 0, 0, 1'b0);
    step();
    check_eq("single_plot", 32'(vga_plot), 32'd1);
    check_eq("single_x", 32'(vga_x), 32'd10);
    check_eq("single_y", 32'(vga_y), 32'd20);
    check_eq("single_c", 32'(vga_colour), 32'd5);
    step();
    check_eq("single_plot_low", 32'(vga_plot), 32'd0);

    // Clipping.
    max_lvl = 0;
    drive(160, 0, 1, 1'b1);   step(); if (level > max_lvl) max_lvl = level;
    drive(0, 120, 2, 1'b1);   step(); if (level > max_lvl) max_lvl = level;
    drive(255, 127, 3, 1'b1); step(); if (level > max_lvl) max_lvl = level;
    drive(159, 119, 4, 1'b1); step(); if (level > max_lvl) max_lvl = level;
    drive(0, 0, 0, 1'b0);
    step();
    check_eq("clip_emit_x", 32'(vga_x), 32'd159);
    check_eq("clip_emit_y", 32'(vga_y), 32'd119);
    step();
    check_eq("clip_count3", 32'(clip_count), 32'd3);
    check_eq("clip_max_level", 32'(max_lvl), 32'd1);

    // Full / backpressure with 17 distinct pixels.
    out_en = 1'b0;
    i = 0;
    for (int k = 0; k < 22; k++) begin
      drive(i + 1, i + 2, i, i < 17);
      acc = in_plot && in_ready;
      step();
      if (acc) i++;
    end
    check_eq("full_accepted", 32'(i), 32'd16);
    check_eq("full_level", 32'(level), 32'd16);
    check_eq("full_ready", 32'(in_ready), 32'd0);
    out_en = 1'b1;
    run = 0;
    for (int k = 0; k < 22; k++) begin
      drive(i + 1, i + 2, i, i < 17);
      acc = in_plot && in_ready;
      step();
      if (acc) i++;
      if (vga_plot) run++;
    end
    check_eq("drain_count", 32'(run), 32'd17);

    // Flush colliding with push and pop.
    out_en = 1'b0;
    for (int k = 0; k < 5; k++) begin drive(k, k, k, 1'b1); step(); end
    check_eq("pre_flush_level", 32'(level), 32'd5);
    run = clip_count;
    flush = 1'b1; out_en = 1'b1; drive(7, 7, 7, 1'b1);
    step();
    flush = 1'b0; drive(0, 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("flush_no_plot", 32'(vga_plot), 32'd0);
    end
    check_eq("flush_clip_kept", 32'(clip_count), 32'(run));

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if (!(in_plot && !in_ready))
        drive($urandom_range(0, 200), $urandom_range(0, 127), $urandom_range(0, 7),
              $urandom_range(0, 3) != 0);
      out_en = ((k / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush  = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0;

    // Mid-drain reset.
    out_en = 1'b0;
    for (int k = 0; k < 4; k++) begin drive(k + 30, k + 40, k, 1'b1); step(); end
    drive(0, 0, 0, 1'b0);
    out_en = 1'b1;
    step();
    check_eq("drain_plot_before_rst", 32'(vga_plot), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_plot", 32'(vga_plot), 32'd0);
    check_eq("midrst_level", 32'(level), 32'd0);
    model_reset();
    out_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Clip counter saturation.
    drive(200, 5, 1, 1'b1);
    for (int k = 0; k < 65537; k++) step();
    drive(0, 0, 0, 1'b0);
    step();
    check_eq("clip_saturated", 32'(clip_count), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
